// File: rtl/dec_check_fsm_pkg.sv
// Shared RC4 key-search constants and the decrypted-message checker state encoding.
// State bits carry the registered outputs directly, so outputs never glitch.
package rc4_pkg;
  localparam int MSG_LEN_DEF = 32;
  localparam int ADDR_W_DEF  = 5;

  localparam logic [7:0] CHAR_LO_DEF = 8'h61;
  localparam logic [7:0] CHAR_HI_DEF = 8'h7A;
  localparam logic [7:0] CHAR_SP_DEF = 8'h20;

  // Field layout: [4]=fin_strobe, [3]=rd_en, [2]=fsm_on, [1:0]=state id
  localparam int ST_FIN = 4;
  localparam int ST_RD  = 3;
  localparam int ST_ON  = 2;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_RD   = 5'b01100,
    S_WAIT = 5'b00101,
    S_CHK  = 5'b00110,
    S_DONE = 5'b10000
  } chk_state_e;
endpackage

// File: rtl/dec_check_fsm_if.sv
// Control and decrypted-memory read bus of the message checker.
interface dec_check_fsm_if #(
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              msg_ok;
  logic [ADDR_W-1:0] fail_idx;
  logic              fsm_on;
  logic              fin_strobe;

  modport master (
    input  start, rd_data,
    output addr, rd_en, msg_ok, fail_idx, fsm_on, fin_strobe
  );

  modport slave (
    output start, rd_data,
    input  addr, rd_en, msg_ok, fail_idx, fsm_on, fin_strobe
  );
endinterface

// File: rtl/dec_check_fsm_char_legal.sv
// Combinational plaintext classifier: a byte is legal if inside [LO,HI] or equal to SP.
module char_legal
  import rc4_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
  parameter logic [7:0] CHAR_HI = CHAR_HI_DEF,
  parameter logic [7:0] CHAR_SP = CHAR_SP_DEF
) (
  input  logic [7:0] i_byte,
  output logic       o_legal
);
  assign o_legal = ((i_byte >= CHAR_LO) && (i_byte <= CHAR_HI)) || (i_byte == CHAR_SP);
endmodule

// File: rtl/dec_check_fsm.sv
// Walks the decrypted message in address order and stops at the first illegal byte.
// Reports pass/fail and the failing index to the key-search controller.
module dec_check_fsm
  import rc4_pkg::*;
#(
  parameter int         MSG_LEN = MSG_LEN_DEF,
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
  parameter logic [7:0] CHAR_HI = CHAR_HI_DEF,
  parameter logic [7:0] CHAR_SP = CHAR_SP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  dec_check_fsm_if.master bus
);
  // One extra bit so MSG_LEN == 2**ADDR_W does not wrap before the last compare
  localparam logic [ADDR_W:0] K_LAST = (ADDR_W+1)'(MSG_LEN - 1);

  chk_state_e        r_state;
  logic [ADDR_W:0]   r_k;
  logic [7:0]        r_byte;
  logic              r_msg_ok;
  logic [ADDR_W-1:0] r_fail_idx;
  logic              w_legal;

  char_legal #(
    .CHAR_LO (CHAR_LO),
    .CHAR_HI (CHAR_HI),
    .CHAR_SP (CHAR_SP)
  ) u_legal (
    .i_byte  (r_byte),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_byte     <= '0;
      r_msg_ok   <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state    <= S_RD;
          r_k        <= '0;
          r_msg_ok   <= 1'b0;
          r_fail_idx <= '0;
        end
        S_RD:   r_state <= S_WAIT;
        S_WAIT: begin
          r_byte  <= bus.rd_data;
          r_state <= S_CHK;
        end
        S_CHK: begin
          if (!w_legal) begin
            r_state    <= S_DONE;
            r_msg_ok   <= 1'b0;
            r_fail_idx <= r_k[ADDR_W-1:0];
          end else if (r_k == K_LAST) begin
            r_state  <= S_DONE;
            r_msg_ok <= 1'b1;
          end else begin
            r_state <= S_RD;
            r_k     <= r_k + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr       = r_k[ADDR_W-1:0];
  assign bus.rd_en      = r_state[ST_RD];
  assign bus.fsm_on     = r_state[ST_ON];
  assign bus.fin_strobe = r_state[ST_FIN];
  assign bus.msg_ok     = r_msg_ok;
  assign bus.fail_idx   = r_fail_idx;
endmodule
